// File: rtl/sig_pkg.sv
// Shared types and constants for the result-signature monitor.
package sig_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_ACCUM  = 2'd2,
        S_DONE   = 2'd3
    } sig_state_e;

    localparam logic [63:0] DEF_POLY = 64'h000000000000001B;

endpackage

// File: rtl/misr_step.sv
// One step of the multiple-input signature register: shift, polynomial feedback
// from the MSB, then fold in the new result word.
module misr_step #(
    parameter int              W    = 64,
    parameter logic [W-1:0]    POLY = '0
) (
    input  logic [W-1:0] sig_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    assign sig_o = {sig_i[W-2:0], 1'b0} ^ (sig_i[W-1] ? POLY : '0) ^ data_i;

endmodule

// File: rtl/result_sig_monitor.sv
// Compacts N_SAMPLES datapath result words into a MISR signature after a
// LATENCY-cycle warm-up and compares it against a golden signature.
module result_sig_monitor
    import sig_pkg::*;
#(
    parameter int           W         = 64,
    parameter int           LATENCY   = 8,
    parameter int           N_SAMPLES = 1024,
    parameter logic [W-1:0] POLY      = sig_pkg::DEF_POLY[W-1:0],
    parameter logic [W-1:0] SEED      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [W-1:0]     result_i,
    input  logic [W-1:0]     expected_sig_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [W-1:0]     sig_o,
    output logic [15:0]      sample_cnt_o,
    output sig_state_e       state_o
);

    // +2 keeps the warm-up counter at least one bit wide when LATENCY is 0.
    localparam int WC_W = $clog2(LATENCY + 2);
    localparam int SC_W = $clog2(N_SAMPLES + 1);

    sig_state_e       state_q, state_d;
    logic [W-1:0]     sig_q, sig_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             pass_q, pass_d;

    logic [W-1:0]     sig_next;
    logic [SC_W-1:0]  cnt_inc;

    misr_step #(
        .W    (W),
        .POLY (POLY)
    ) u_misr_step (
        .sig_i  (sig_q),
        .data_i (result_i),
        .sig_o  (sig_next)
    );

    assign cnt_inc = cnt_q + SC_W'(1);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    pass_d  = 1'b0;
                    state_d = (LATENCY == 0) ? S_ACCUM : S_WARMUP;
                end
            end
            S_WARMUP: begin
                wcnt_d = wcnt_q + WC_W'(1);
                if (wcnt_q == WC_W'(LATENCY - 1)) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                sig_d = sig_next;
                cnt_d = cnt_inc;
                // Compare the signature being written so pass_o is valid with done_o.
                if (cnt_inc == SC_W'(N_SAMPLES)) begin
                    state_d = S_DONE;
                    pass_d  = (sig_next == expected_sig_i);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy_o       = (state_q == S_WARMUP) || (state_q == S_ACCUM);
    assign done_o       = (state_q == S_DONE);
    assign pass_o       = pass_q;
    assign sig_o        = sig_q;
    assign sample_cnt_o = 16'(cnt_q);
    assign state_o      = state_q;

endmodule
